// File: rtl/ex_muldiv.sv
// rtl/ex_muldiv.sv - RV32M iterative multiply/divide execute unit
module ex_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] op1_i,
  input  logic [31:0] op2_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        ready_o,
  output logic [31:0] result_o,
  output logic        reg_we_o,
  output logic [4:0]  reg_waddr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] opnd_q, opnd_d;     // multiplicand or divisor magnitude
  logic [63:0] acc_q, acc_d;       // {hi/remainder, lo/multiplier-or-quotient}
  logic        neg_q, neg_d;       // product / quotient sign
  logic        rneg_q, rneg_d;     // remainder sign (dividend sign)
  logic [31:0] result_q, result_d;

  // Decode of the incoming request
  logic [2:0]  f3_in;
  logic        sgn1, sgn2, n1, n2;
  logic [31:0] abs1, abs2;
  logic        div_zero, div_ovf, fast_path, accept;
  logic [31:0] fast_res;

  assign f3_in = inst_i[14:12];
  assign sgn1  = (f3_in == F3_MULH) || (f3_in == F3_MULHSU) ||
                 (f3_in == F3_DIV)  || (f3_in == F3_REM);
  assign sgn2  = (f3_in == F3_MULH) || (f3_in == F3_DIV) || (f3_in == F3_REM);
  assign n1    = sgn1 & op1_i[31];
  assign n2    = sgn2 & op2_i[31];
  assign abs1  = n1 ? (32'd0 - op1_i) : op1_i;
  assign abs2  = n2 ? (32'd0 - op2_i) : op2_i;

  // Divide corner cases resolve in a single cycle without iterating
  assign div_zero  = f3_in[2] && (op2_i == 32'd0);
  assign div_ovf   = ((f3_in == F3_DIV) || (f3_in == F3_REM)) &&
                     (op1_i == 32'h8000_0000) && (op2_i == 32'hFFFF_FFFF);
  assign fast_path = div_zero || div_ovf;
  assign fast_res  = div_zero ? (f3_in[1] ? op1_i : 32'hFFFF_FFFF)
                              : (f3_in[1] ? 32'd0 : 32'h8000_0000);
  assign accept    = start_i && !flush_i && (state_q == S_IDLE);

  // One shared iteration step: shift-add for multiply, restoring step for divide
  logic [32:0] mul_sum;
  logic [32:0] div_shift, div_diff;
  logic [63:0] step_acc;

  assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign div_shift = acc_q[63:31];
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign step_acc  = f3_q[2]
                   ? (div_diff[32] ? {div_shift[31:0], acc_q[30:0], 1'b0}
                                   : {div_diff[31:0],  acc_q[30:0], 1'b1})
                   : {mul_sum, acc_q[31:1]};

  // Sign correction and result selection applied to the final step
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix, final_res;

  assign prod_fix = neg_q  ? (64'd0 - step_acc) : step_acc;
  assign quo_fix  = neg_q  ? (32'd0 - step_acc[31:0]) : step_acc[31:0];
  assign rem_fix  = rneg_q ? (32'd0 - step_acc[63:32]) : step_acc[63:32];

  // Pick low product, high product, quotient or remainder by funct3
  always_comb begin
    final_res = prod_fix[63:32];
    case (f3_q)
      F3_MUL:                      final_res = prod_fix[31:0];
      F3_MULH, F3_MULHSU, F3_MULHU: final_res = prod_fix[63:32];
      F3_DIV, F3_DIVU:             final_res = quo_fix;
      F3_REM, F3_REMU:             final_res = rem_fix;
      default:                     final_res = prod_fix[63:32];
    endcase
  end

  // FSM next state and handshake outputs; flush overrides every state
  always_comb begin
    state_d = state_q;
    busy_o  = 1'b0;
    ready_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i && !flush_i) begin
          busy_o  = 1'b1;
          state_d = fast_path ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        busy_o = 1'b1;
        if (cnt_q == 6'd31) state_d = S_DONE;
      end
      S_DONE: begin
        ready_o = !flush_i;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) state_d = S_IDLE;
  end

  // Datapath next-state: operand capture on accept, iterate while calculating
  always_comb begin
    cnt_d    = cnt_q;
    f3_d     = f3_q;
    rd_d     = rd_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;
    if (accept) begin
      f3_d   = f3_in;
      rd_d   = inst_i[11:7];
      cnt_d  = 6'd0;
      neg_d  = n1 ^ n2;
      rneg_d = n1;
      if (f3_in[2]) begin
        opnd_d = abs2;
        acc_d  = {32'd0, abs1};
      end else begin
        opnd_d = abs1;
        acc_d  = {32'd0, abs2};
      end
      if (fast_path) result_d = fast_res;
    end else if (state_q == S_CALC && !flush_i) begin
      acc_d = step_acc;
      cnt_d = cnt_q + 6'd1;
      if (cnt_q == 6'd31) result_d = final_res;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      f3_q     <= 3'd0;
      rd_q     <= 5'd0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      f3_q     <= f3_d;
      rd_q     <= rd_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign result_o    = result_q;
  assign reg_we_o    = ready_o;
  assign reg_waddr_o = rd_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// tb/tb_ex_muldiv.sv - directed self-checking bench for ex_muldiv
module tb_ex_muldiv;

  logic        clk;
  logic        rst;
  logic        start_i;
  logic [31:0] inst_i;
  logic [31:0] op1_i;
  logic [31:0] op2_i;
  logic        flush_i;
  logic        busy_o;
  logic        ready_o;
  logic [31:0] result_o;
  logic        reg_we_o;
  logic [4:0]  reg_waddr_o;

  int checks = 0;
  int errors = 0;
  int nready = 0;

  ex_muldiv dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .inst_i     (inst_i),
    .op1_i      (op1_i),
    .op2_i      (op2_i),
    .flush_i    (flush_i),
    .busy_o     (busy_o),
    .ready_o    (ready_o),
    .result_o   (result_o),
    .reg_we_o   (reg_we_o),
    .reg_waddr_o(reg_waddr_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count write-back pulses, sampled mid-low-phase
  always @(negedge clk) begin
    #2;
    if (ready_o) nready++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk_inst(input logic [2:0] f3, input logic [4:0] rd);
    return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
  endfunction

  // Issue one operation at the current negedge and follow it to its write-back
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat);
    int cyc;
    logic busy_ok;
    start_i = 1'b1;
    inst_i  = mk_inst(f3, rd);
    op1_i   = a;
    op2_i   = b;
    #1;
    busy_ok = busy_o;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    cyc = 1;
    while (!ready_o && cyc < 40) begin
      if (!busy_o) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, lat);
    check({tag, " result"}, result_o, exp);
    check({tag, " waddr"}, {27'd0, reg_waddr_o}, {27'd0, rd});
    check({tag, " we"}, {31'd0, reg_we_o}, 32'd1);
    check({tag, " busy before done"}, {31'd0, busy_ok}, 32'd1);
    check({tag, " busy in done"}, {31'd0, busy_o}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int n0;
    int cyc;
    rst     = 1'b1;
    start_i = 1'b0;
    inst_i  = 32'd0;
    op1_i   = 32'd0;
    op2_i   = 32'd0;
    flush_i = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset busy", {31'd0, busy_o}, 32'd0);
    check("reset ready", {31'd0, ready_o}, 32'd0);
    check("reset we", {31'd0, reg_we_o}, 32'd0);
    check("reset waddr", {27'd0, reg_waddr_o}, 32'd0);
    check("reset result", result_o, 32'd0);
    @(negedge clk);

    // Multiply family
    do_op("mul",    3'b000, 5'd5,  32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
    do_op("mulhu",  3'b011, 5'd6,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    do_op("mulh",   3'b001, 5'd7,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
    do_op("mulhsu", 3'b010, 5'd8,  32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 33);

    // Divide family
    do_op("div",  3'b100, 5'd10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    do_op("rem",  3'b110, 5'd11, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    do_op("divu", 3'b101, 5'd12, 32'd100,       32'd7, 32'd14,        33);
    do_op("remu", 3'b111, 5'd0,  32'd100,       32'd7, 32'd2,         33);

    // Single-cycle corner cases
    do_op("divu by 0", 3'b101, 5'd13, 32'd5,        32'd0,        32'hFFFF_FFFF, 1);
    do_op("rem by 0",  3'b110, 5'd14, 32'd5,        32'd0,        32'd5,         1);
    do_op("div ovf",   3'b100, 5'd15, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    do_op("rem ovf",   3'b110, 5'd16, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Flush in cycle 10 of a divide, then a multiply starting in cycle 11
    n0 = nready;
    start_i = 1'b1;
    inst_i  = mk_inst(3'b101, 5'd20);
    op1_i   = 32'd1000;
    op2_i   = 32'd3;
    @(negedge clk);
    start_i = 1'b0;
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    #1;
    check("flush ready", {31'd0, ready_o}, 32'd0);
    check("flush we", {31'd0, reg_we_o}, 32'd0);
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    check("flush busy after", {31'd0, busy_o}, 32'd0);
    do_op("mul after flush", 3'b000, 5'd21, 32'd1234, 32'd1000, 32'd1234000, 33);
    check("flush pulse count", nready - n0, 32'd1);

    // Reset in cycle 20 of a multiply
    n0 = nready;
    start_i = 1'b1;
    inst_i  = mk_inst(3'b000, 5'd22);
    op1_i   = 32'd3;
    op2_i   = 32'd5;
    @(negedge clk);
    start_i = 1'b0;
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst busy", {31'd0, busy_o}, 32'd0);
    check("rst ready", {31'd0, ready_o}, 32'd0);
    check("rst we", {31'd0, reg_we_o}, 32'd0);
    check("rst waddr", {27'd0, reg_waddr_o}, 32'd0);
    check("rst result", result_o, 32'd0);
    repeat (40) @(negedge clk);
    check("rst pulse count", nready - n0, 32'd0);

    // start_i held through the whole operation is accepted once only
    n0 = nready;
    start_i = 1'b1;
    inst_i  = mk_inst(3'b000, 5'd9);
    op1_i   = 32'd6;
    op2_i   = 32'd7;
    @(negedge clk);
    cyc = 1;
    while (!ready_o && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    check("held latency", cyc, 33);
    check("held result", result_o, 32'd42);
    start_i = 1'b0;
    repeat (40) @(negedge clk);
    check("held pulse count", nready - n0, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
